// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: tag/state stage of the set-associative cache.
// Looks up the request tag in the indexed set, reports hit/miss, the selected
// way and any eviction, then updates valid, dirty and true-LRU age state.
// Optional feature macro: CACHE_TAG_STATS_EN enables the hit/miss counters;
// without it hit_count and miss_count are tied to zero.
module cache_tag_lookup #(
    parameter int i_size = 64,
    parameter int d_size = 6,
    parameter int c_size = 14,
    parameter int a_size = 8,
    localparam int WW = $clog2(a_size),
    localparam int IW = c_size - WW - d_size,
    localparam int TW = i_size - IW - d_size
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [TW-1:0] req_tag,
    input  logic [IW-1:0] req_index,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_hit,
    output logic [WW-1:0] rsp_way,
    output logic          rsp_evict,
    output logic          rsp_evict_dirty,
    output logic [TW-1:0] rsp_evict_tag,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
);
    localparam int SETS = 1 << IW;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_CLEAR, S_RESP} state_t;

    state_t state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [TW-1:0] ltag_q, ltag_d;
    logic [IW-1:0] idx_q, idx_d, clr_idx_q, clr_idx_d;
    logic          hit_q, hit_d;
    logic [WW-1:0] hit_way_q, hit_way_d, victim_q, victim_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
    logic [WW-1:0] rsp_way_q, rsp_way_d;
    logic          rsp_evict_q, rsp_evict_d, rsp_edirty_q, rsp_edirty_d;
    logic [TW-1:0] rsp_etag_q, rsp_etag_d;

    // Per-set state; tags need no reset because valid gates every use.
    logic [SETS-1:0][a_size-1:0]         valid_q, dirty_q;
    logic [SETS-1:0][a_size-1:0][WW-1:0] age_q;
    logic [TW-1:0] tag_mem_q [SETS][a_size];

    // Single row write port shared by UPDATE and CLEAR.
    logic                         row_we, tag_we;
    logic [IW-1:0]                wr_idx;
    logic [a_size-1:0]            row_valid, row_dirty;
    logic [a_size-1:0][WW-1:0]    row_age;

    logic          lk_hit;
    logic [WW-1:0] lk_way, lru_way, lk_victim, acc_way, old_age;
    logic          cnt_hit_ev, cnt_miss_ev;

    assign acc_way   = hit_q ? hit_way_q : victim_q;
    assign old_age   = age_q[idx_q][acc_way];
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_evict = rsp_evict_q;
    assign rsp_evict_dirty = rsp_edirty_q;
    assign rsp_evict_tag   = rsp_etag_q;

    // Tag compare and victim choice: lowest invalid way, else the LRU way.
    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        lru_way   = '0;
        for (int w = 0; w < a_size; w++) begin
            if (valid_q[idx_q][w] && tag_mem_q[idx_q][w] == ltag_q) begin
                lk_hit = 1'b1;
                lk_way = WW'(w);
            end
            if (age_q[idx_q][w] == WW'(a_size - 1))
                lru_way = WW'(w);
        end
        lk_victim = lru_way;
        for (int w = a_size - 1; w >= 0; w--) begin
            if (!valid_q[idx_q][w])
                lk_victim = WW'(w);
        end
    end

    // Next-state, row update and response capture.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ltag_d      = ltag_q;
        idx_d       = idx_q;
        clr_idx_d   = clr_idx_q;
        hit_d       = hit_q;
        hit_way_d   = hit_way_q;
        victim_d    = victim_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_way_d   = rsp_way_q;
        rsp_evict_d = rsp_evict_q;
        rsp_edirty_d = rsp_edirty_q;
        rsp_etag_d  = rsp_etag_q;
        row_we      = 1'b0;
        tag_we      = 1'b0;
        wr_idx      = idx_q;
        row_valid   = valid_q[idx_q];
        row_dirty   = dirty_q[idx_q];
        row_age     = age_q[idx_q];
        cnt_hit_ev  = 1'b0;
        cnt_miss_ev = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    ltag_d    = req_tag;
                    idx_d     = req_index;
                    clr_idx_d = '0;
                    state_d   = (req_op == 2'd3) ? S_CLEAR : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d     = lk_hit;
                hit_way_d = lk_way;
                victim_d  = lk_victim;
                state_d   = S_UPDATE;
            end
            S_UPDATE: begin
                if (!op_q[1]) begin
                    // Read/write: fill on miss, promote the accessed way.
                    row_we = 1'b1;
                    tag_we = !hit_q;
                    for (int w = 0; w < a_size; w++) begin
                        if (WW'(w) == acc_way)
                            row_age[w] = '0;
                        else if (age_q[idx_q][w] < old_age)
                            row_age[w] = age_q[idx_q][w] + WW'(1);
                    end
                    row_valid[acc_way] = 1'b1;
                    if (op_q[0])
                        row_dirty[acc_way] = 1'b1;
                    else if (!hit_q)
                        row_dirty[acc_way] = 1'b0;
                    rsp_hit_d    = hit_q;
                    rsp_way_d    = acc_way;
                    rsp_evict_d  = !hit_q && valid_q[idx_q][victim_q];
                    rsp_edirty_d = rsp_evict_d && dirty_q[idx_q][victim_q];
                    rsp_etag_d   = rsp_evict_d ? tag_mem_q[idx_q][victim_q] : '0;
                    cnt_hit_ev   = hit_q;
                    cnt_miss_ev  = !hit_q;
                end else begin
                    // Invalidate: drop the line on hit, ages untouched.
                    if (hit_q) begin
                        row_we = 1'b1;
                        row_valid[hit_way_q] = 1'b0;
                        row_dirty[hit_way_q] = 1'b0;
                    end
                    rsp_hit_d    = hit_q;
                    rsp_way_d    = hit_q ? hit_way_q : '0;
                    rsp_evict_d  = 1'b0;
                    rsp_edirty_d = 1'b0;
                    rsp_etag_d   = '0;
                end
                state_d = S_RESP;
            end
            S_CLEAR: begin
                row_we    = 1'b1;
                wr_idx    = clr_idx_q;
                row_valid = '0;
                row_dirty = '0;
                for (int w = 0; w < a_size; w++)
                    row_age[w] = WW'(w);
                clr_idx_d = clr_idx_q + IW'(1);
                if (clr_idx_q == IW'(SETS - 1)) begin
                    rsp_hit_d    = 1'b0;
                    rsp_way_d    = '0;
                    rsp_evict_d  = 1'b0;
                    rsp_edirty_d = 1'b0;
                    rsp_etag_d   = '0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                // First RESP cycle raises rsp_valid; hold until accepted.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            ltag_q       <= '0;
            idx_q        <= '0;
            clr_idx_q    <= '0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            victim_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_evict_q  <= 1'b0;
            rsp_edirty_q <= 1'b0;
            rsp_etag_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            ltag_q       <= ltag_d;
            idx_q        <= idx_d;
            clr_idx_q    <= clr_idx_d;
            hit_q        <= hit_d;
            hit_way_q    <= hit_way_d;
            victim_q     <= victim_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_evict_q  <= rsp_evict_d;
            rsp_edirty_q <= rsp_edirty_d;
            rsp_etag_q   <= rsp_etag_d;
        end
    end

    // Valid/dirty/age arrays: reset to empty sets with ages in way order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < a_size; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WW'(w);
                end
            end
        end else if (row_we) begin
            valid_q[wr_idx] <= row_valid;
            dirty_q[wr_idx] <= row_dirty;
            age_q[wr_idx]   <= row_age;
        end
    end

    // Tag array: written only when a miss fills the victim way.
    always_ff @(posedge clk) begin
        if (tag_we)
            tag_mem_q[idx_q][victim_q] <= ltag_q;
    end

`ifdef CACHE_TAG_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_hit_ev && hit_cnt_q != '1)
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (cnt_miss_ev && miss_cnt_q != '1)
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = cnt_hit_ev | cnt_miss_ev;
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
